// File: rtl/mdom_scdb_hdr_pkg.sv
// Shared definitions for the SCDB header serializer: bundle layout, frame
// geometry, FSM state encoding, CRC constants and the waveform length helper.
// Frame geometry depends on the MDOM_SCDB_HDR_CRC_EN macro (9 words with CRC).
package mdom_scdb_hdr_pkg;

   localparam int SCDB_LTC_W   = 49;
   localparam int SCDB_ADDR_W  = 11;
   localparam int SCDB_BSUM_W  = 19;
   localparam int SCDB_CH_W    = 5;
   localparam int SCDB_PRE_W   = 5;
   localparam int SCDB_BLS_W   = 3;
   localparam int SCDB_HDR_W   = 111;
   localparam int SCDB_WORD_W  = 16;

   // LSB offset of each field inside the 111-bit bundle
   localparam int LTC_LSB      = 0;
   localparam int START_LSB    = 49;
   localparam int STOP_LSB     = 60;
   localparam int TRIG_LSB     = 71;
   localparam int CNST_LSB     = 73;
   localparam int PRE_LSB      = 74;
   localparam int SYNC_LSB     = 79;
   localparam int BSUM_LSB     = 80;
   localparam int BLS_LSB      = 99;
   localparam int BVALID_LSB   = 102;
   localparam int COINC_LSB    = 103;
   localparam int PARTIAL_LSB  = 104;
   localparam int CONT_LSB     = 105;
   localparam int CH_LSB       = 106;

   localparam logic [3:0] START_NIBBLE_DEF = 4'hA;

`ifdef MDOM_SCDB_HDR_CRC_EN
   localparam int FRAME_WORDS = 9;
`else
   localparam int FRAME_WORDS = 8;
`endif

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Declared msb first, so ltc lands at bit 0 and channel_idx at the top
   typedef struct packed {
      logic [SCDB_CH_W-1:0]   channel_idx;
      logic                   continued_wfm;
      logic                   partial_wfm;
      logic                   local_coinc;
      logic                   bsum_valid;
      logic [SCDB_BLS_W-1:0]  bsum_len_sel;
      logic [SCDB_BSUM_W-1:0] bsum;
      logic                   sync_rdy;
      logic [SCDB_PRE_W-1:0]  pre_conf;
      logic                   cnst_run;
      logic [1:0]             trig_src;
      logic [SCDB_ADDR_W-1:0] stop_addr;
      logic [SCDB_ADDR_W-1:0] start_addr;
      logic [SCDB_LTC_W-1:0]  ltc;
   } scdb_hdr_t;

   // Inclusive span of a circular buffer region: 1..2^ADDR_W
   function automatic logic [SCDB_ADDR_W:0] wfm_len_f(
      input logic [SCDB_ADDR_W-1:0] start_addr,
      input logic [SCDB_ADDR_W-1:0] stop_addr
   );
      logic [SCDB_ADDR_W-1:0] span;
      span = stop_addr - start_addr;
      return {1'b0, span} + (SCDB_ADDR_W+1)'(1);
   endfunction

endpackage

// File: rtl/mdom_scdb_hdr_serializer_crc.sv
// mdom_crc16_w16: combinational CRC-16-CCITT next state for one 16-bit word,
// bits consumed msb first, no reflection. Used only when MDOM_SCDB_HDR_CRC_EN
// is defined.
module mdom_crc16_w16
   import mdom_scdb_hdr_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [15:0] data_in,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   // Shift the 16 data bits through the CRC register in one combinational step
   always_comb begin
      c = crc_in;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ data_in[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                    c = {c[14:0], 1'b0};
      end
      crc_out = c;
   end

endmodule

// File: rtl/mdom_scdb_hdr_serializer.sv
// mdom_scdb_hdr_serializer: pops SCDB headers from an FWFT FIFO and emits each
// as a fixed frame of 16-bit words on a valid/ready stream.
// Handshake: a word transfers on a clock edge where out_valid && out_ready;
// while out_valid && !out_ready, out_data and out_last hold their value.
// Optional macro MDOM_SCDB_HDR_CRC_EN appends a CRC-16-CCITT word (W8).
module mdom_scdb_hdr_serializer
   import mdom_scdb_hdr_pkg::*;
#(
   parameter logic [3:0] START_NIBBLE = START_NIBBLE_DEF,
   parameter int         LTC_W        = SCDB_LTC_W,
   parameter int         ADDR_W       = SCDB_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [SCDB_HDR_W-1:0] hdr_bundle,
   input  logic                  hdr_empty,
   output logic                  hdr_rd,
   output logic [15:0]           out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_WORDS - 1);

   state_t          state, state_nxt;
   logic [3:0]      word_idx, idx_nxt;
   scdb_hdr_t       hdr_in, hdr_q;
   logic [LTC_W-1:0] ltc_q;
   logic [ADDR_W:0] wfm_len_q;
   logic            frame_done;
   logic [15:0]     word;

   assign hdr_in = hdr_bundle;
   assign ltc_q  = hdr_q.ltc;

   // State, word index, latched header and frame counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         word_idx  <= '0;
         hdr_q     <= '0;
         wfm_len_q <= '0;
         frame_cnt <= '0;
      end else begin
         state    <= state_nxt;
         word_idx <= idx_nxt;
         if (hdr_rd) begin
            hdr_q     <= hdr_in;
            wfm_len_q <= wfm_len_f(hdr_in.start_addr, hdr_in.stop_addr);
         end
         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Next state, FIFO pop and stream handshake outputs
   always_comb begin
      state_nxt  = state;
      idx_nxt    = word_idx;
      hdr_rd     = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            // rst_n gate keeps the FIFO from being popped during a reset cycle
            if (rst_n && enable && !hdr_empty) begin
               hdr_rd    = 1'b1;
               idx_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (word_idx == LAST_IDX);
            if (out_ready) begin
               if (word_idx == LAST_IDX) begin
                  frame_done = 1'b1;
                  idx_nxt    = '0;
                  state_nxt  = IDLE;
               end else begin
                  idx_nxt = word_idx + 4'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MDOM_SCDB_HDR_CRC_EN
   logic [15:0] crc_q, crc_nxt;

   mdom_crc16_w16 u_crc (
      .crc_in  (crc_q),
      .data_in (out_data),
      .crc_out (crc_nxt)
   );

   // Running CRC over W0..W7, restarted whenever a new header is taken
   always_ff @(posedge clk) begin
      if (!rst_n)                                             crc_q <= CRC_INIT;
      else if (hdr_rd)                                        crc_q <= CRC_INIT;
      else if (out_valid && out_ready && word_idx != LAST_IDX) crc_q <= crc_nxt;
   end
`endif

   // Word map from the latched header; bus reads zero while idle
   always_comb begin
      word = '0;
      case (word_idx)
         4'd0: word = {START_NIBBLE, hdr_q.channel_idx, hdr_q.trig_src, hdr_q.cnst_run,
                       hdr_q.sync_rdy, hdr_q.local_coinc, hdr_q.partial_wfm,
                       hdr_q.continued_wfm};
         4'd1: word = {hdr_q.pre_conf, hdr_q.start_addr};
         4'd2: word = {hdr_q.bsum_len_sel, hdr_q.bsum_valid, 1'b0, hdr_q.stop_addr};
         4'd3: word = {hdr_q.bsum[18:16], ltc_q[48:36]};
         4'd4: word = ltc_q[35:20];
         4'd5: word = ltc_q[19:4];
         4'd6: word = {ltc_q[3:0], hdr_q.bsum[15:4]};
         4'd7: word = {hdr_q.bsum[3:0], wfm_len_q};
`ifdef MDOM_SCDB_HDR_CRC_EN
         4'd8: word = crc_q;
`endif
         default: word = '0;
      endcase
      out_data = (state == SEND) ? word : 16'h0000;
   end

endmodule
